// File: rtl/pwm_cfg_arbiter.sv
// PWM configuration register bank with a two-port arbitrated write path.
// Port 0 (SPI front-end) has priority; port 1 (sequencer) is forced through
// after STARVE_LIMIT consecutive port-0 grants while it is waiting.
module pwm_cfg_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_data,
    output logic              req1_ready,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              wr_done,
    output logic              wr_src,
    output logic              addr_err
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 5;
    localparam int unsigned CNT_W    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_W-1:0] ADDR_OUT_LO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_OUT_HI  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_PWM_LO  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_PWM_HI  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_DUTY    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK0 = 2'd1,
        ACK1 = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   starve_q;
    logic [CNT_W-1:0]   starve_d;
    logic               below_limit;
    logic               wr_en;
    logic               wr_port;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    assign below_limit = (32'(starve_q) < STARVE_LIMIT);

    // State and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Arbitration: next state and next starvation count
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (!req1_valid) begin
                    starve_d = '0;
                end
                if (req0_valid && (!req1_valid || below_limit)) begin
                    state_d = ACK0;
                    // port 0 only wins a tie while below the limit, so no overflow
                    if (req1_valid) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (req1_valid) begin
                    state_d  = ACK1;
                    starve_d = '0;
                end
            end
            ACK0:    state_d = IDLE;
            ACK1:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready pulses follow the granted state; one port at a time by construction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
        end else begin
            req0_ready <= (state_d == ACK0);
            req1_ready <= (state_d == ACK1);
        end
    end

    // Requesters hold addr/data until ready, so the live inputs are the sampled ones
    assign wr_en   = (state_q == ACK0) || (state_q == ACK1);
    assign wr_port = (state_q == ACK1);
    assign wr_addr = wr_port ? req1_addr : req0_addr;
    assign wr_data = wr_port ? req1_data : req0_data;

    // Register bank write at the end of the ACK cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_OUT_LO: en_reg_out_7_0  <= wr_data;
                ADDR_OUT_HI: en_reg_out_15_8 <= wr_data;
                ADDR_PWM_LO: en_reg_pwm_7_0  <= wr_data;
                ADDR_PWM_HI: en_reg_pwm_15_8 <= wr_data;
                ADDR_DUTY:   pwm_duty_cycle  <= wr_data;
                default:     ;
            endcase
        end
    end

    // Write status, aligned with the new register value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_done  <= 1'b0;
            wr_src   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wr_done  <= wr_en;
            addr_err <= wr_en && (wr_addr > ADDR_LAST);
            if (wr_en) begin
                wr_src <= wr_port;
            end
        end
    end

endmodule
